// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, funct, ALU F-code constants and state enum
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU F-code with a legality flag
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD: alucontrol = ALU_ADD;
      FN_SUB: alucontrol = ALU_SUB;
      FN_AND: alucontrol = ALU_AND;
      FN_OR:  alucontrol = ALU_OR;
      FN_SLT: alucontrol = ALU_SLT;
      // Shifts fall back to add and flag illegal when the shifter is absent.
      FN_SLL: if (SHIFT_EN) alucontrol = ALU_SLL; else valid = 1'b0;
      FN_SRL: if (SHIFT_EN) alucontrol = ALU_SRL; else valid = 1'b0;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore control FSM for the multicycle MIPS datapath
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic [3:0] dec_alucontrol;
  logic       dec_valid;

  alu_decoder #(.SHIFT_EN(SHIFT_EN)) u_alu_decoder (
    .funct      (funct),
    .alucontrol (dec_alucontrol),
    .valid      (dec_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    alucontrol = ALU_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = dec_alucontrol;
        // An unsupported funct aborts before writeback.
        if (dec_valid) state_d = S_ALUWB;
        else           illegal = 1'b1;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pcen = pcwrite | (branch & zero);

    // Write enables must be quiet for the whole reset assertion, not just after the edge.
    if (!reset_n) begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter SHIFT_EN, default 1, enables decoding of sll/srl; when 0 those functs are illegal.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  instruction opcode from instruction register.
REQ-005 funct  in  6  R-type function field from instruction register.
REQ-006 zero  in  1  ALU Zero flag, same cycle.
REQ-007 alucontrol  out  4  ALU F code: and 0000, or 0001, add 0010, sll 0100, srl 0101, sub 1010, slt 1011.
REQ-008 alusrca  out  1  0=PC, 1=register A.
REQ-009 alusrcb  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-010 pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 iord, regdst, memtoreg  out  1 each  address/dest/writeback muxes.
REQ-012 irwrite, memwrite, regwrite, pcen  out  1 each  write enables.
REQ-013 illegal  out  1  one-cycle pulse on unsupported op/funct.
REQ-014 state  out  4  current state, debug.

Function
REQ-015 Moore FSM; states/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-016 Transitions: FETCH->DECODE; DECODE by op: lw(100011)/sw(101011)->MEMADR, R(000000)->EXECUTE, beq(000100)->BRANCH, addi(001000)->ADDIEX, j(000010)->JUMP, other->FETCH with illegal=1.
REQ-017 MEMADR->MEMRD if lw else MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-018 Unlisted outputs are 0 in each state; alucontrol defaults to add (0010).
REQ-019 FETCH: alusrcb=01, irwrite=1, pcwrite=1 (pcsrc 00).
REQ-020 DECODE: alusrcb=11. MEMADR, ADDIEX: alusrca=1, alusrcb=10.
REQ-021 MEMRD: iord=1. MEMWR: iord=1, memwrite=1. MEMWB: memtoreg=1, regwrite=1.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl.
REQ-023 EXECUTE with unsupported funct: illegal=1 that cycle, next state FETCH (ALUWB skipped, no regwrite).
REQ-024 ALUWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-025 BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, branch=1.
REQ-026 JUMP: pcsrc=10, pcwrite=1.
REQ-027 pcen = pcwrite | (branch & zero), combinational; only path where zero affects outputs.
REQ-028 Instruction latency: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; illegal op 2 cycles.

Reset
REQ-029 reset_n low forces state=FETCH immediately; irwrite, memwrite, regwrite, pcen, illegal forced 0 while low.
REQ-030 Reset mid-instruction abandons it; first rising edge after release executes FETCH.

Structure
REQ-031 Package mips_ctrl_pkg holds opcode, funct and ALU F-code constants and the state enum.
REQ-032 Sub-module alu_decoder (combinational funct->alucontrol plus valid flag) instantiated once.
REQ-033 State register is the only sequential element.

Verification
REQ-034 Reset release, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-035 op=000000, funct=100010 -> EXECUTE alucontrol=1010; ALUWB regdst=1, regwrite=1.
REQ-036 op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01; zero=0 -> pcen=0; next state FETCH.
REQ-037 op=111111 -> illegal pulse in DECODE, next FETCH, no write enable asserted; SHIFT_EN=0 with funct=000000 -> illegal in EXECUTE.
REQ-038 reset_n low during MEMWR -> memwrite drops to 0 asynchronously, state=0 without clock edge.
